io_arbiter: RTL and testbench
=============================

Name: io_arbiter

Overview:
- Two-requester arbiter in front of the 4-word memory-mapped IO port (status, LED, switch-low, switch-high).
- Requester 0 is the CPU load/store path; requester 1 is the debug/monitor path.
- Grants one access per cycle using round-robin. Drives the IO port's pRead/pWrite/addr/pWriteData. Tracks the IO port's one-cycle registered read latency and routes pReadData back to the owning requester.

Parameters:
- ADDR_W, 2, IO word-address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req0 / req1  in  1  access request; held with we/addr/wdata stable until gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  IO word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data valid
- rdata0 / rdata1  out  DATA_W  read data; 0 when the matching rvalid is low
- pRead  out  1  IO port read strobe
- pWrite  out  1  IO port write strobe
- pAddr  out  ADDR_W  IO port address
- pWriteData  out  DATA_W  IO port write data
- pReadData  in  DATA_W  IO port read data; registered, valid the cycle after pRead

Behaviour:
- State machine `arb_state_t`: IDLE, RD_WAIT. Registers: state, rr_last (last granted requester), rd_owner.
- IDLE, no req: all outputs 0.
- IDLE, winner selection:
  - Exactly one req: that requester wins.
  - Both req: the requester not equal to rr_last wins.
- IDLE, grant cycle (same cycle, combinational):
  - gnt of winner = 1.
  - pAddr/pWriteData = winner's addr/wdata.
  - pWrite = winner we; pRead = ~winner we.
  - rr_last <= winner.
- IDLE, write grant: stays IDLE; the next grant is possible the next cycle (1 write/cycle).
- IDLE, read grant: rd_owner <= winner; state <= RD_WAIT.
- RD_WAIT (exactly 1 cycle):
  - No grant; pRead = pWrite = 0; pAddr/pWriteData = 0.
  - rvalid[rd_owner] = 1; rdata[rd_owner] = pReadData; the other requester's rvalid/rdata = 0.
  - state <= IDLE.
  - Read throughput: 1 per 2 cycles.
- Loser: its req stays pending and wins the next grant slot (guaranteed by round-robin, no starvation).
- Latency:
  - gnt is 0 cycles after req when IDLE.
  - rvalid is 1 cycle after the read gnt.
- Reset:
  - rst high: state = IDLE, rr_last = 1 (requester 0 wins the first tie), rd_owner = 0.
  - While rst is high, every output is forced to 0 in the same cycle.
  - rst during RD_WAIT aborts: no rvalid is issued for that read.
- req deasserted before gnt: legal. The request is dropped; no state change.
- Arbiter never drives pRead and pWrite together.

Optional Feature:
- IO_ARB_STATS_EN defined:
  - Adds outputs gcnt0, gcnt1 (16 bits each): per-requester grant counters.
  - Each increments on its gnt, saturates at 16'hFFFF, and is cleared by rst.
- Not defined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package io_pkg:
  - Constants IO_ADDR_STATUS=2'b00, IO_ADDR_LED=2'b01, IO_ADDR_SW_LO=2'b10, IO_ADDR_SW_HI=2'b11.
  - typedef enum arb_state_t {IDLE, RD_WAIT}.
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], rr_last.
  - Outputs: valid, winner.
  - io_arbiter owns all state.

Test Plan:
- req0 write addr=01 wdata=0x00000ABC, req1 idle → gnt0=1 same cycle, pWrite=1, pAddr=01, pWriteData=0xABC; no rvalid.
- req1 read addr=10; IO port returns 0x0000005A next cycle → cycle0: gnt1=1, pRead=1; cycle1: rvalid1=1, rdata1=0x5A, rvalid0=0, no grant.
- Both req as writes, held, from reset → grants alternate gnt0, gnt1, gnt0 on consecutive cycles.
- Both req as reads, held → gnt0 @t0, rvalid0 @t1, gnt1 @t2, rvalid1 @t3.
- Read granted, rst asserted in the RD_WAIT cycle → no rvalid; the next cycle is IDLE; the next tie goes to requester 0.
- IO_ARB_STATS_EN: 3 grants to req0 and 1 grant to req1 → gcnt0=3, gcnt1=1; preload near 16'hFFFF and verify saturation.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared IO-port address map and arbiter state type.
package io_pkg;

    localparam logic [1:0] IO_ADDR_STATUS = 2'b00;
    localparam logic [1:0] IO_ADDR_LED    = 2'b01;
    localparam logic [1:0] IO_ADDR_SW_LO  = 2'b10;
    localparam logic [1:0] IO_ADDR_SW_HI  = 2'b11;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; a tie goes to the requester not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~rr_last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_arbiter.sv
// io_arbiter: round-robin arbiter for two requesters onto the 4-word IO port.
// Defining IO_ARB_STATS_EN adds saturating per-requester grant counters gcnt0/gcnt1.
module io_arbiter
    import io_pkg::*;
#(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              pRead,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWriteData,
    input  logic [DATA_W-1:0] pReadData
`ifdef IO_ARB_STATS_EN
    ,
    output logic [15:0]       gcnt0,
    output logic [15:0]       gcnt1
`endif
);

    arb_state_t        state;
    logic              rr_last;
    logic              rd_owner;
    logic              pick_valid;
    logic              winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arb2 u_rr_arb2 (
        .req    ({req1, req0}),
        .rr_last(rr_last),
        .valid  (pick_valid),
        .winner (winner)
    );

    assign win_we    = winner ? we1 : we0;
    assign win_addr  = winner ? addr1 : addr0;
    assign win_wdata = winner ? wdata1 : wdata0;

    // Grant and read-return are combinational off the state; reset blanks everything at once.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rvalid0    = 1'b0;
        rvalid1    = 1'b0;
        rdata0     = '0;
        rdata1     = '0;
        pRead      = 1'b0;
        pWrite     = 1'b0;
        pAddr      = '0;
        pWriteData = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt0       = ~winner;
                        gnt1       = winner;
                        pWrite     = win_we;
                        pRead      = ~win_we;
                        pAddr      = win_addr;
                        pWriteData = win_wdata;
                    end
                end
                RD_WAIT: begin
                    rvalid0 = ~rd_owner;
                    rvalid1 = rd_owner;
                    if (rd_owner) rdata1 = pReadData;
                    else          rdata0 = pReadData;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            rd_owner <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        rr_last <= winner;
                        if (!win_we) begin
                            rd_owner <= winner;
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
        end else begin
            if (gnt0 && gcnt0 != 16'hFFFF) gcnt0 <= gcnt0 + 16'd1;
            if (gnt1 && gcnt1 != 16'hFFFF) gcnt1 <= gcnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed and random stimulus against a transaction-level model of the arbiter.
// Build with IO_ARB_STATS_EN defined to also check the grant counters.
module tb_io_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0][1:0]   addr;
    logic [1:0][31:0]  wdata;
    logic              gnt0, gnt1, rvalid0, rvalid1, pRead, pWrite;
    logic [31:0]       rdata0, rdata1, pWriteData, pReadData;
    logic [1:0]        pAddr;
`ifdef IO_ARB_STATS_EN
    logic [15:0]       gcnt0, gcnt1;
`endif

    always #5 clk = ~clk;

    io_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .pRead(pRead), .pWrite(pWrite), .pAddr(pAddr), .pWriteData(pWriteData),
        .pReadData(pReadData)
`ifdef IO_ARB_STATS_EN
        , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
    );

    // Simple IO port: 4 words, registered read data one cycle after pRead.
    logic [31:0] port_mem [4];
    always @(posedge clk) begin
        if (pWrite) port_mem[pAddr] <= pWriteData;
        pReadData <= pRead ? port_mem[pAddr] : 32'h0;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Transaction-level model state.
    logic [31:0] mem_m [4];
    int          pend_rd;     // requester whose read data is due this cycle, -1 if none
    int          last_w;      // last requester served
    logic [31:0] exp_rdata;
    int          cnt_m [2];
    logic [1:0]  obs_gnt, obs_rv;
    logic        obs_prd, obs_pwr;
    logic [1:0]  obs_addr;
    logic [31:0] obs_wd, obs_rd0, obs_rd1;

    task automatic step();
        int          w;
        logic [1:0]  e_gnt, e_rv;
        logic        e_prd, e_pwr;
        logic [1:0]  e_addr;
        logic [31:0] e_wd, e_rd0, e_rd1;
        @(negedge clk);
        w = -1;
        e_gnt = '0; e_rv = '0; e_prd = 0; e_pwr = 0; e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
        if (!rst) begin
            if (pend_rd >= 0) begin
                e_rv[pend_rd] = 1'b1;
                if (pend_rd == 0) e_rd0 = exp_rdata; else e_rd1 = exp_rdata;
            end else begin
                if (req[0] && req[1]) w = (last_w == 0) ? 1 : 0;
                else if (req[0])      w = 0;
                else if (req[1])      w = 1;
                if (w >= 0) begin
                    e_gnt[w] = 1'b1;
                    e_addr   = addr[w];
                    e_wd     = wdata[w];
                    e_pwr    = we[w];
                    e_prd    = !we[w];
                end
            end
        end
        obs_gnt = {gnt1, gnt0}; obs_rv = {rvalid1, rvalid0};
        obs_prd = pRead; obs_pwr = pWrite; obs_addr = pAddr; obs_wd = pWriteData;
        obs_rd0 = rdata0; obs_rd1 = rdata1;
        check("gnt", 64'(obs_gnt), 64'(e_gnt));
        check("strobes", 64'({obs_prd, obs_pwr}), 64'({e_prd, e_pwr}));
        check("paddr", 64'(obs_addr), 64'(e_addr));
        check("pwdata", 64'(obs_wd), 64'(e_wd));
        check("rvalid", 64'(obs_rv), 64'(e_rv));
        check("rdata", {obs_rd1, obs_rd0}, {e_rd1, e_rd0});
`ifdef IO_ARB_STATS_EN
        check("gcnt", {32'(gcnt1), 32'(gcnt0)}, {32'(cnt_m[1]), 32'(cnt_m[0])});
`endif
        if (rst) begin
            pend_rd = -1; last_w = 1; cnt_m[0] = 0; cnt_m[1] = 0;
        end else if (pend_rd >= 0) begin
            pend_rd = -1;
        end else if (w >= 0) begin
            last_w = w;
            if (cnt_m[w] < 65535) cnt_m[w]++;
            if (we[w]) mem_m[addr[w]] = wdata[w];
            else begin
                pend_rd   = w;
                exp_rdata = mem_m[addr[w]];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic w_, input logic [1:0] a,
                           input logic [31:0] d);
        req[r] = v; we[r] = w_; addr[r] = a; wdata[r] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            port_mem[i] = 32'h1000 + 32'(i);
            mem_m[i]    = 32'h1000 + 32'(i);
        end
        port_mem[2] = 32'h5A; mem_m[2] = 32'h5A;
        pend_rd = -1; last_w = 1; cnt_m[0] = 0; cnt_m[1] = 0; exp_rdata = '0;
        req = '0; we = '0; addr = '0; wdata = '0;
        rst = 1'b1;
        #1;
        step();
        check("reset_quiet", 64'({obs_gnt, obs_rv, obs_prd, obs_pwr}), 64'h0);
        rst = 1'b0;

        // Single write from requester 0.
        set_req(0, 1, 1, 2'b01, 32'h0000_0ABC);
        step();
        check("wr_gnt0", 64'(obs_gnt), 64'h1);
        check("wr_pwrite", 64'({obs_pwr, obs_prd}), 64'h2);
        check("wr_paddr", 64'(obs_addr), 64'h1);
        check("wr_pwdata", 64'(obs_wd), 64'hABC);
        check("wr_no_rv", 64'(obs_rv), 64'h0);
        req = '0;
        step();

        // Single read from requester 1, address 2.
        set_req(1, 1, 0, 2'b10, 32'h0);
        step();
        check("rd_gnt1", 64'({obs_gnt, obs_prd}), 64'h5);
        req = '0;
        step();
        check("rd_rv1", 64'({obs_gnt, obs_rv}), 64'h2);
        check("rd_data1", {obs_rd1, obs_rd0}, {32'h5A, 32'h0});

        // Held write tie from reset alternates 0, 1, 0.
        do_reset();
        set_req(0, 1, 1, 2'b00, 32'h11); set_req(1, 1, 1, 2'b11, 32'h22);
        step(); check("tie_w0", 64'(obs_gnt), 64'h1);
        step(); check("tie_w1", 64'(obs_gnt), 64'h2);
        step(); check("tie_w2", 64'(obs_gnt), 64'h1);

        // Held read tie: gnt0, rvalid0, gnt1, rvalid1.
        do_reset();
        set_req(0, 1, 0, 2'b11, 32'h0); set_req(1, 1, 0, 2'b00, 32'h0);
        step(); check("tie_r_t0", 64'({obs_gnt, obs_rv}), 64'h4);
        step(); check("tie_r_t1", 64'({obs_gnt, obs_rv}), 64'h1);
        step(); check("tie_r_t2", 64'({obs_gnt, obs_rv}), 64'h8);
        step(); check("tie_r_t3", 64'({obs_gnt, obs_rv}), 64'h2);

        // Reset during RD_WAIT drops the read; next tie goes to requester 0.
        step();
        check("abort_gnt", 64'(obs_gnt), 64'h1);
        rst = 1'b1;
        step(); check("abort_no_rv", 64'({obs_gnt, obs_rv}), 64'h0);
        rst = 1'b0;
        step(); check("abort_tie0", 64'({obs_gnt, obs_rv}), 64'h4);
        req = '0;
        step();

        // Random traffic obeying the hold-until-grant protocol.
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (obs_gnt[r] || !req[r]) begin
                    if (obs_gnt[r] || $urandom_range(1, 0) == 1)
                        set_req(r, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                                2'($urandom_range(3, 0)), $urandom);
                end else if ($urandom_range(15, 0) == 0) begin
                    req[r] = 1'b0;
                end
            end
            rst = ($urandom_range(99, 0) == 0);
            step();
        end
        rst = 1'b0;

`ifdef IO_ARB_STATS_EN
        do_reset();
        req = '0;
        for (int i = 0; i < 3; i++) begin set_req(0, 1, 1, 2'b01, 32'(i)); step(); end
        req = '0; set_req(1, 1, 1, 2'b01, 32'h9); step();
        req = '0; step();
        check("gcnt_small", {32'(gcnt1), 32'(gcnt0)}, {32'd1, 32'd3});
        set_req(0, 1, 1, 2'b00, 32'h7);
        for (int i = 0; i < 65540; i++) step();
        req = '0; step();
        check("gcnt_sat", 64'(gcnt0), 64'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
